// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types and default constants for the PWM sequencer.
//   ch_state_e        : per-channel sequencer state (IDLE, ARMED, RUN)
//   DEF_PERIOD_CYCLES : default frame length in clock cycles (20 ms @ 50 MHz)
//   DEF_IDLE_WIDTH    : default neutral pulse width in cycles (1.5 ms @ 50 MHz)
package pwm_seq_pkg;

  localparam int unsigned DEF_PERIOD_CYCLES = 1000000;
  localparam int unsigned DEF_IDLE_WIDTH    = 75000;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } ch_state_e;

endpackage

// File: rtl/pwm_seq_channel.sv
// pwm_seq_channel: one PWM channel. Holds the sequencer FSM, step index,
// remaining-frames counter, latched pulse width and the output compare.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_cnt          : shared frame counter
//   i_boundary     : frame counter is at 0 this cycle
//   i_trigger      : start request (level)
//   i_abort        : stop request (wins over trigger)
//   o_rd_addr      : profile table entry this channel wants to see
//   i_rd_width     : width field of that entry (already clipped)
//   i_rd_dur       : duration field of that entry, frames (0 = end marker)
//   o_signal       : registered PWM output
//   o_busy         : channel armed or running
//   o_done         : one-cycle pulse on completion or abort
module pwm_seq_channel
  import pwm_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned DUR_W      = 16,
  parameter int unsigned NUM_STEPS  = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned IDLE_WIDTH = DEF_IDLE_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic              i_boundary,
  input  logic              i_trigger,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [CNT_W-1:0]  i_rd_width,
  input  logic [DUR_W-1:0]  i_rd_dur,
  output logic              o_signal,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [CNT_W-1:0]  W_IDLE    = CNT_W'(IDLE_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(NUM_STEPS - 1);

  ch_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_step, w_step_nxt;
  logic [DUR_W-1:0]  r_frames_left, w_frames_nxt;
  logic [CNT_W-1:0]  r_width, w_width_nxt;
  logic              r_signal, r_done, w_done_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_frames_nxt = r_frames_left;
    w_width_nxt  = r_width;
    w_done_nxt   = 1'b0;
    // ARMED always loads entry 0; RUN only ever needs the entry after the current one.
    o_rd_addr    = (r_state == RUN) ? r_step + 1'b1 : '0;

    if (r_state != IDLE && i_abort) begin
      // Width is held until the next boundary so the pulse in flight is not cut short.
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b1;
      if (i_boundary) w_width_nxt = W_IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_boundary) w_width_nxt = W_IDLE;
          if (i_trigger && !i_abort) w_state_nxt = ARMED;
        end
        ARMED: begin
          if (i_boundary) begin
            if (i_rd_dur == '0) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_width_nxt = W_IDLE;
            end else begin
              w_state_nxt  = RUN;
              w_step_nxt   = '0;
              w_width_nxt  = i_rd_width;
              w_frames_nxt = i_rd_dur;
            end
          end
        end
        RUN: begin
          if (i_boundary) begin
            if (r_frames_left != DUR_W'(1)) begin
              w_frames_nxt = r_frames_left - 1'b1;
            end else if (r_step == LAST_STEP || i_rd_dur == '0) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_width_nxt = W_IDLE;
            end else begin
              w_step_nxt   = r_step + 1'b1;
              w_width_nxt  = i_rd_width;
              w_frames_nxt = i_rd_dur;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_step        <= '0;
      r_frames_left <= '0;
      r_width       <= W_IDLE;
      r_signal      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_step        <= w_step_nxt;
      r_frames_left <= w_frames_nxt;
      r_width       <= w_width_nxt;
      r_done        <= w_done_nxt;
      // Compare against the next width so a boundary-cycle reload applies to counter 0 itself.
      r_signal      <= (i_cnt < w_width_nxt);
    end
  end

  assign o_signal = r_signal;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: multi-channel servo/ESC PWM generator playing a shared,
// writable speed profile per channel on trigger, neutral pulse otherwise.
//   clock, reset : system clock, asynchronous active-high reset
//   trigger      : per-channel start request
//   abort        : per-channel stop request
//   tbl_we       : profile table write strobe
//   tbl_addr     : table entry index
//   tbl_width    : entry pulse width in cycles (clipped to the frame length)
//   tbl_dur      : entry length in frames (0 = end-of-sequence)
//   signal       : PWM outputs
//   busy         : channel armed or running
//   done         : one-cycle completion/abort pulse
//   frame_start  : one-cycle pulse, aligned with the first cycle of each frame's output
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter  int unsigned NUM_CH        = 2,
  parameter  int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter  int unsigned IDLE_WIDTH    = DEF_IDLE_WIDTH,
  parameter  int unsigned NUM_STEPS     = 4,
  parameter  int unsigned DUR_W         = 16,
  localparam int unsigned CNT_W         = $clog2(PERIOD_CYCLES),
  localparam int unsigned ADDR_W        = $clog2(NUM_STEPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] abort,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [CNT_W-1:0]  tbl_width,
  input  logic [DUR_W-1:0]  tbl_dur,
  output logic [NUM_CH-1:0] signal,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic              frame_start
);

  localparam int unsigned     CNT_MAX  = (1 << CNT_W) - 1;
  localparam int unsigned     CLIP_INT = (PERIOD_CYCLES > CNT_MAX) ? CNT_MAX : PERIOD_CYCLES;
  localparam logic [CNT_W-1:0] W_CLIP   = CNT_W'(CLIP_INT);
  localparam logic [CNT_W-1:0] W_IDLE   = CNT_W'(IDLE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [DUR_W-1:0] dur;
  } tbl_entry_t;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_frame_start;
  logic              w_boundary;
  logic [CNT_W-1:0]  w_wr_width;
  tbl_entry_t        r_tbl [NUM_STEPS];
  logic [ADDR_W-1:0] w_rd_addr [NUM_CH];

  assign w_boundary = (r_cnt == '0);
  // A width at or above the frame length means 100 % duty.
  assign w_wr_width = (tbl_width > W_CLIP) ? W_CLIP : tbl_width;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      r_cnt         <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
        r_tbl[i] <= '{width: W_IDLE, dur: '0};
      end
    end else if (tbl_we) begin
      r_tbl[tbl_addr] <= '{width: w_wr_width, dur: tbl_dur};
    end
  end

  assign frame_start = r_frame_start;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tbl_entry_t w_entry;
    assign w_entry = r_tbl[w_rd_addr[g]];

    pwm_seq_channel #(
      .CNT_W      (CNT_W),
      .DUR_W      (DUR_W),
      .NUM_STEPS  (NUM_STEPS),
      .ADDR_W     (ADDR_W),
      .IDLE_WIDTH (IDLE_WIDTH)
    ) u_ch (
      .i_clk      (clock),
      .i_rst      (reset),
      .i_cnt      (r_cnt),
      .i_boundary (w_boundary),
      .i_trigger  (trigger[g]),
      .i_abort    (abort[g]),
      .o_rd_addr  (w_rd_addr[g]),
      .i_rd_width (w_entry.width),
      .i_rd_dur   (w_entry.dur),
      .o_signal   (signal[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g])
    );
  end

endmodule
